// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray conversion, parameter legality checks and the default pointer width.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

    localparam int DEF_FIFO_DEPTH_BIT = 5;
    localparam int PTR_W              = DEF_FIFO_DEPTH_BIT + 1;

    // Conversions work on a wide word so any pointer width up to 32 can zero-extend in and truncate out.
    typedef logic [31:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin     = '0;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic bit ratio_legal(input int din_width, input int dout_width);
        return (dout_width == din_width) || (dout_width == 2 * din_width) ||
               (din_width == 2 * dout_width);
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
// Async active-low reset clears every stage to zero.
module gray_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/write_full_ctrl.sv
// Write-domain pointer, Gray publication and full/almost-full/level/overflow flags of the async FIFO.
// The read Gray pointer is only observed (via gray_sync), never modified here.
module write_full_ctrl
    import fifo_pkg::*;
#(
    parameter int DATAIN_WIDTH       = 8,
    parameter int DATAOUT_WIDTH      = 16,
    parameter int FIFO_DEPTH_BIT     = 5,
    parameter int ALMOST_FULL_MARGIN = 2,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                      w_clk,
    input  logic                      w_rst_n,
    input  logic                      w_en,
    input  logic                      clr_overflow,
    input  logic [FIFO_DEPTH_BIT:0]   read_addr_gray,
    output logic                      w_accept,
    output logic [FIFO_DEPTH_BIT-1:0] write_addr,
    output logic [FIFO_DEPTH_BIT:0]   write_addr_gray,
    output logic                      flag_full,
    output logic                      flag_almost_full,
    output logic [FIFO_DEPTH_BIT:0]   write_level,
    output logic                      overflow
);

    localparam int WPTR_W    = FIFO_DEPTH_BIT + 1;
    localparam int DEPTH     = 1 << FIFO_DEPTH_BIT;
    localparam int AF_THRESH = DEPTH - ALMOST_FULL_MARGIN;

    if (!ratio_legal(DATAIN_WIDTH, DATAOUT_WIDTH)) begin : g_bad_ratio
        $error("write_full_ctrl: DATAOUT_WIDTH/DATAIN_WIDTH ratio must be 1 or 2");
    end
    if (ALMOST_FULL_MARGIN < 1 || ALMOST_FULL_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("write_full_ctrl: ALMOST_FULL_MARGIN out of range");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("write_full_ctrl: SYNC_STAGES must be at least 2");
    end

    logic [WPTR_W-1:0] wbin;
    logic [WPTR_W-1:0] wbin_next;
    logic [WPTR_W-1:0] wgray_next;
    logic [WPTR_W-1:0] rgray_s;
    logic [WPTR_W-1:0] rbin_s;
    logic [WPTR_W-1:0] level_next;
    logic [WPTR_W-1:0] full_pattern;

    gray_sync #(
        .WIDTH  (WPTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rgray_sync (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .d     (read_addr_gray),
        .q     (rgray_s)
    );

    // Reset also blocks the strobe so the RAM never sees a write while the pointer is held at zero.
    assign w_accept     = w_en & ~flag_full & w_rst_n;
    assign write_addr   = wbin[FIFO_DEPTH_BIT-1:0];
    assign wbin_next    = wbin + {{(WPTR_W-1){1'b0}}, w_accept};
    assign wgray_next   = WPTR_W'(bin2gray(32'(wbin_next)));
    assign rbin_s       = WPTR_W'(gray2bin(32'(rgray_s)));
    assign level_next   = wbin_next - rbin_s;
    assign full_pattern = {~rgray_s[WPTR_W-1:WPTR_W-2], rgray_s[WPTR_W-3:0]};

    // All flags are computed from the next pointer so they line up with the published Gray value.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wbin             <= '0;
            write_addr_gray  <= '0;
            flag_full        <= 1'b0;
            flag_almost_full <= 1'b0;
            write_level      <= '0;
            overflow         <= 1'b0;
        end else begin
            wbin             <= wbin_next;
            write_addr_gray  <= wgray_next;
            flag_full        <= (wgray_next == full_pattern);
            flag_almost_full <= (level_next >= WPTR_W'(AF_THRESH));
            write_level      <= level_next;
            overflow         <= (w_en & flag_full) | (overflow & ~clr_overflow);
        end
    end

endmodule

// File: tb/tb_write_full_ctrl.sv
// Randomised scoreboard bench for write_full_ctrl: a count-based reference model predicts each cycle,
// a negedge monitor pops the predictions and compares them with the DUT outputs.
module tb_write_full_ctrl;

    localparam int DEPTH_BIT = 5;
    localparam int DEPTH     = 32;
    localparam int PTR_MOD   = 64;
    localparam int MARGIN    = 2;
    localparam int SYNC      = 2;

    typedef struct {
        bit         rst;
        logic       acc;
        logic [4:0] addr;
        logic [5:0] gray;
        logic       full;
        logic       almost;
        logic [5:0] level;
        logic       ovf;
    } exp_t;

    logic       w_clk = 1'b0;
    logic       w_rst_n = 1'b1;
    logic       w_en = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [5:0] read_addr_gray = '0;
    logic       w_accept;
    logic [4:0] write_addr;
    logic [5:0] write_addr_gray;
    logic       flag_full;
    logic       flag_almost_full;
    logic [5:0] write_level;
    logic       overflow;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    int   hist[$];
    int   wr, rd, m_level;
    bit   m_full, m_almost, m_ovf;
    logic [5:0] prev_gray;
    bit   prev_valid = 1'b0;

    always #5 w_clk = ~w_clk;

    write_full_ctrl #(
        .DATAIN_WIDTH       (8),
        .DATAOUT_WIDTH      (16),
        .FIFO_DEPTH_BIT     (DEPTH_BIT),
        .ALMOST_FULL_MARGIN (MARGIN),
        .SYNC_STAGES        (SYNC)
    ) dut (
        .w_clk            (w_clk),
        .w_rst_n          (w_rst_n),
        .w_en             (w_en),
        .clr_overflow     (clr_overflow),
        .read_addr_gray   (read_addr_gray),
        .w_accept         (w_accept),
        .write_addr       (write_addr),
        .write_addr_gray  (write_addr_gray),
        .flag_full        (flag_full),
        .flag_almost_full (flag_almost_full),
        .write_level      (write_level),
        .overflow         (overflow)
    );

    function automatic logic [5:0] gray_of(input int n);
        int m;
        m = n % PTR_MOD;
        return 6'(m ^ (m >> 1));
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wr = 0; rd = 0; m_level = 0;
        m_full = 0; m_almost = 0; m_ovf = 0;
        hist = {};
        repeat (SYNC) hist.push_back(0);
    endtask

    // Called at posedge+2: drive one cycle, predict its outputs, then advance the model across the edge.
    task automatic apply_stimulus(input bit en, input bit clr, input bit rd_step);
        exp_t e;
        int   seen;
        if (rd_step && rd < wr) begin
            rd++;
            read_addr_gray = gray_of(rd);
        end
        w_en = en;
        clr_overflow = clr;
        e.rst = 0;
        e.acc = en && !m_full;
        e.addr = 5'(wr % DEPTH);
        e.gray = gray_of(wr);
        e.full = m_full;
        e.almost = m_almost;
        e.level = 6'(m_level);
        e.ovf = m_ovf;
        sb.push_back(e);
        seen = hist.pop_front();
        hist.push_back(rd);
        if (e.acc) wr++;
        m_ovf = (en && m_full) || (m_ovf && !clr);
        m_level = wr - seen;
        m_full = (m_level == DEPTH);
        m_almost = (m_level >= DEPTH - MARGIN);
        @(posedge w_clk);
        #2;
    endtask

    task automatic set_read(input int n);
        if (n <= wr) rd = n;
        read_addr_gray = gray_of(rd);
    endtask

    task automatic do_reset(input int cycles, input bit en);
        exp_t e;
        w_rst_n = 1'b0;
        w_en = en;
        clr_overflow = 1'b0;
        read_addr_gray = '0;
        #1;
        check_output("rst_gray", write_addr_gray, 0);
        check_output("rst_level", write_level, 0);
        check_output("rst_full", flag_full, 0);
        check_output("rst_almost", flag_almost_full, 0);
        check_output("rst_ovf", overflow, 0);
        check_output("rst_addr", write_addr, 0);
        model_reset();
        e = '{rst: 1, acc: 0, addr: 0, gray: 0, full: 0, almost: 0, level: 0, ovf: 0};
        for (int i = 0; i < cycles; i++) begin
            sb.push_back(e);
            @(posedge w_clk);
            #1;
        end
        #1;
        w_rst_n = 1'b1;
    endtask

    // Monitor: pops one prediction per cycle and also checks that the published Gray moves by one bit.
    initial begin
        exp_t e;
        forever begin
            @(negedge w_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("w_accept", w_accept, e.acc);
                check_output("write_addr", write_addr, e.addr);
                check_output("write_addr_gray", write_addr_gray, e.gray);
                check_output("flag_full", flag_full, e.full);
                check_output("flag_almost_full", flag_almost_full, e.almost);
                check_output("write_level", write_level, e.level);
                check_output("overflow", overflow, e.ovf);
                if (!e.rst && prev_valid)
                    check_output("gray_one_bit", int'($countones(prev_gray ^ write_addr_gray) <= 1), 1);
                prev_gray = write_addr_gray;
                prev_valid = !e.rst;
            end
        end
    end

    initial begin
        int  start_wr;
        bit  hit;
        model_reset();
        @(posedge w_clk);
        #2;

        do_reset(3, 1'b1);
        apply_stimulus(1, 0, 0);
        check_output("first_gray", write_addr_gray, 1);
        check_output("first_level", write_level, 1);

        repeat (31) apply_stimulus(1, 0, 0);
        check_output("fill_level", write_level, 32);
        check_output("fill_full", flag_full, 1);
        apply_stimulus(1, 0, 0);
        check_output("ovf_set", overflow, 1);
        check_output("ptr_held", write_addr, 0);
        check_output("level_held", write_level, 32);

        apply_stimulus(0, 1, 0);
        check_output("ovf_clear", overflow, 0);
        apply_stimulus(1, 0, 0);
        apply_stimulus(1, 1, 0);
        check_output("ovf_set_wins", overflow, 1);

        set_read(4);
        apply_stimulus(0, 0, 0);
        apply_stimulus(0, 0, 0);
        check_output("full_held_2edges", flag_full, 1);
        apply_stimulus(0, 0, 0);
        check_output("full_release_3edges", flag_full, 0);
        check_output("release_level", write_level, 28);
        apply_stimulus(0, 1, 0);

        start_wr = wr;
        for (int i = 0; i < 1500 && (wr - start_wr) < 200; i++)
            apply_stimulus(($urandom % 4) != 0, 0, ($urandom % 2) == 0);
        check_output("stream_200", int'((wr - start_wr) >= 200), 1);

        set_read(wr);
        repeat (4) apply_stimulus(0, 0, 0);
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (m_level == 17) hit = 1;
            else apply_stimulus(($urandom % 4) != 0, 0, ($urandom % 3) == 0);
        end
        check_output("reach_level17", int'(hit), 1);
        do_reset(2, 1'b0);

        for (int i = 0; i < 40; i++) apply_stimulus(1, 0, 0);
        check_output("refill_full", flag_full, 1);
        check_output("refill_level", write_level, 32);
        check_output("refill_ovf", overflow, 1);

        @(posedge w_clk);
        #2;
        check_output("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
